// File: rtl/man_encoder_tx.sv
// Manchester line encoder: valid/ready word intake, burst preamble,
// MSB-first serialisation with HALF_BIT clocks per half-bit.
module man_encoder_tx #(
  parameter int DATA_W        = 8,
  parameter int HALF_BIT      = 16,
  parameter int PREAMBLE_BITS = 4,
  parameter int CONVENTION    = 0
) (
  input  logic              clk_32Mhz,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              encoded_data,
  output logic              tx_busy,
  output logic              tx_done
);

  localparam int HCW  = $clog2(HALF_BIT);
  localparam int MAXB = (DATA_W > PREAMBLE_BITS) ? DATA_W : PREAMBLE_BITS;
  localparam int BCW  = $clog2(MAXB + 1);

  localparam logic [HCW-1:0] HALF_LAST = HCW'(HALF_BIT - 1);
  localparam logic [BCW-1:0] DATA_LAST = BCW'(DATA_W - 1);
  localparam logic [BCW-1:0] PRE_LAST  =
    BCW'((PREAMBLE_BITS > 0) ? PREAMBLE_BITS - 1 : 0);
  localparam logic CONV = (CONVENTION != 0);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PRE  = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [HCW-1:0]    half_q, half_d;
  logic              phase_q, phase_d;
  logic [BCW-1:0]    bit_q, bit_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              line_q, line_d;
  logic              done_q, done_d;

  logic              half_end;
  logic              bit_end;
  logic              last_data;
  logic              hs;
  logic              cur_bit;
  logic              new_first;
  logic [DATA_W-1:0] sh_next;

  // Half-level of a bit: IEEE sends ~b then b; Thomas inverts both.
  function automatic logic lvl(input logic b, input logic ph);
    return b ^ ~ph ^ CONV;
  endfunction

  assign half_end  = (half_q == HALF_LAST);
  assign bit_end   = half_end & phase_q;
  assign last_data = (state_q == S_DATA) && (bit_q == DATA_LAST) && bit_end;

  assign tx_ready = rst & ((state_q == S_IDLE) | last_data);
  assign hs       = tx_valid & tx_ready;

  assign cur_bit   = (state_q == S_PRE) ? ~bit_q[0] : shreg_q[DATA_W-1];
  assign sh_next   = shreg_q << 1;
  assign new_first = (PREAMBLE_BITS > 0) ? 1'b1 : tx_data[DATA_W-1];

  always_comb begin
    state_d = state_q;
    half_d  = half_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    line_d  = line_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        line_d = 1'b0;
        if (hs) begin
          state_d = (PREAMBLE_BITS > 0) ? S_PRE : S_DATA;
          half_d  = '0;
          phase_d = 1'b0;
          bit_d   = '0;
          shreg_d = tx_data;
          line_d  = lvl(new_first, 1'b0);
        end
      end
      S_PRE: begin
        if (!half_end) begin
          half_d = half_q + 1'b1;
        end else begin
          half_d = '0;
          if (!phase_q) begin
            phase_d = 1'b1;
            line_d  = lvl(cur_bit, 1'b1);
          end else begin
            phase_d = 1'b0;
            if (bit_q == PRE_LAST) begin
              state_d = S_DATA;
              bit_d   = '0;
              line_d  = lvl(shreg_q[DATA_W-1], 1'b0);
            end else begin
              bit_d  = bit_q + 1'b1;
              line_d = lvl(bit_q[0], 1'b0);
            end
          end
        end
      end
      S_DATA: begin
        if (!half_end) begin
          half_d = half_q + 1'b1;
        end else begin
          half_d = '0;
          if (!phase_q) begin
            phase_d = 1'b1;
            line_d  = lvl(cur_bit, 1'b1);
          end else begin
            phase_d = 1'b0;
            if (bit_q == DATA_LAST) begin
              done_d = 1'b1;
              bit_d  = '0;
              if (hs) begin
                shreg_d = tx_data;
                line_d  = lvl(tx_data[DATA_W-1], 1'b0);
              end else begin
                state_d = S_IDLE;
                shreg_d = '0;
                line_d  = 1'b0;
              end
            end else begin
              bit_d   = bit_q + 1'b1;
              shreg_d = sh_next;
              line_d  = lvl(sh_next[DATA_W-1], 1'b0);
            end
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        half_d  = '0;
        phase_d = 1'b0;
        bit_d   = '0;
        shreg_d = '0;
        line_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_32Mhz or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      half_q  <= '0;
      phase_q <= 1'b0;
      bit_q   <= '0;
      shreg_q <= '0;
      line_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      half_q  <= half_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      line_q  <= line_d;
      done_q  <= done_d;
    end
  end

  assign encoded_data = line_q;
  assign tx_busy      = (state_q != S_IDLE);
  assign tx_done      = done_q;

endmodule
